// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : core-wide constants and the fetch queue entry type
// Revision  : 1.0
// ============================================================================
package riscv_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int PC_W        = 64;
  localparam int INSTR_W     = 32;

  // addi x0, x0, 0 -- inserted by IF/ID when it is flushed
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// fifo_sync : synchronous circular FIFO with occupancy count and flush
// Revision  : 1.0
// ============================================================================
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO can still take a write when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : fetch PC, pipelined imem requests and instruction queue.
//               FETCH_QUEUE_BYPASS_EN adds a same-cycle response-to-output path.
// Revision    : 1.0
// ============================================================================
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int           CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]  DEPTH_SUM = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            accept;
  logic            rsp_live;
  fetch_entry_t    q_wdata;
  fetch_entry_t    q_rdata;

  // Credit rule: queued plus in-flight never exceeds DEPTH, so every
  // response is guaranteed a slot.
  assign imem_req_valid = !reset && !redirect_valid &&
                          (({1'b0, count} + {1'b0, outst}) < DEPTH_SUM);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (drop == '0) && !redirect_valid;

  always_comb begin
    q_wdata       = '0;
    q_wdata.pc    = PC_W'(rsp_pc);
    q_wdata.instr = INSTR_W'(imem_rsp_instr);
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  assign bypass    = rsp_live && q_empty && !reset;
  assign q_push    = rsp_live && !(bypass && out_ready);
  assign q_pop     = !q_empty && out_ready;
  assign out_valid = !q_empty || bypass;
  assign out_instr = bypass ? imem_rsp_instr : q_rdata.instr[ILEN-1:0];
  assign out_pc    = bypass ? rsp_pc         : q_rdata.pc[XLEN-1:0];
`else
  assign q_push    = rsp_live;
  assign q_pop     = !q_empty && out_ready;
  assign out_valid = !q_empty;
  assign out_instr = q_rdata.instr[ILEN-1:0];
  assign out_pc    = q_rdata.pc[XLEN-1:0];
`endif

  fifo_sync #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (count),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // everything still in flight belongs to the old path and must be discarded
      outst    <= outst - CW'(imem_rsp_valid);
      drop     <= outst - CW'(imem_rsp_valid);
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      end
      outst <= outst + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop != '0) begin
          drop <= drop - CW'(1);
        end else begin
          rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
        end
      end
    end
  end

endmodule
`default_nettype wire
